// File: rtl/healthcare_pkg.sv
// Shared constants for the phase-1 patient monitor.
//   Pressure normal window : P_LO..P_HI inclusive (6-bit pressure code)
//   Temperature window     : T_LO..T_HI inclusive (8-bit computed temperature)
//   T_SHIFT                : right shift applied to coef*sensor
//   pH windows             : group A (types 0..3) and group B (types 4..7)
package healthcare_pkg;

    localparam logic [5:0]  P_LO    = 6'd12;
    localparam logic [5:0]  P_HI    = 6'd20;
    localparam logic [7:0]  T_LO    = 8'd35;
    localparam logic [7:0]  T_HI    = 8'd39;
    localparam int unsigned T_SHIFT = 3;

    localparam logic [3:0]  PH_LO_A = 4'd6;
    localparam logic [3:0]  PH_HI_A = 4'd9;
    localparam logic [3:0]  PH_LO_B = 4'd5;
    localparam logic [3:0]  PH_HI_B = 4'd8;

    typedef enum logic {
        BT_GROUP_A = 1'b0,   // blood types 0..3
        BT_GROUP_B = 1'b1    // blood types 4..7
    } bt_group_e;

    // The group is selected by the type code MSB.
    function automatic bt_group_e bt_group(input logic [2:0] btype);
        return btype[2] ? BT_GROUP_B : BT_GROUP_A;
    endfunction

    function automatic logic ph_abnormal(input logic [3:0] ph, input logic [2:0] btype);
        logic r_abn;
        r_abn = 1'b0;
        unique case (bt_group(btype))
            BT_GROUP_A: r_abn = (ph < PH_LO_A) || (ph > PH_HI_A);
            BT_GROUP_B: r_abn = (ph < PH_LO_B) || (ph > PH_HI_B);
        endcase
        return r_abn;
    endfunction

endpackage

// File: rtl/healthcare_system_phase1_if.sv
// Sensor-sample / abnormality-flag bundle for the phase-1 monitor.
//   master : sensor front-end side, drives the sample, observes the flags
//   slave  : monitor side, receives the sample, produces the flags
// Signal names match the monitor's port names one-for-one.
interface healthcare_system_phase1_if;

    logic [5:0] pressureData;
    logic [3:0] bloodPH;
    logic [2:0] bloodType;
    logic [7:0] fdSensorValue;
    logic [7:0] fdFactoryValue;
    logic [7:0] bloodSensor;
    logic [4:0] factotyBaseTemp;
    logic [3:0] factotyTempCoef;
    logic [3:0] tempSensorValue;

    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic [3:0] glycemicIndex;
    logic       lowTempAbnormality;
    logic       highTempAbnormality;
    logic       fallDetected;

    modport master (
        output pressureData, bloodPH, bloodType, fdSensorValue, fdFactoryValue,
               bloodSensor, factotyBaseTemp, factotyTempCoef, tempSensorValue,
        input  presureAbnormality, bloodAbnormality, glycemicIndex,
               lowTempAbnormality, highTempAbnormality, fallDetected
    );

    modport slave (
        input  pressureData, bloodPH, bloodType, fdSensorValue, fdFactoryValue,
               bloodSensor, factotyBaseTemp, factotyTempCoef, tempSensorValue,
        output presureAbnormality, bloodAbnormality, glycemicIndex,
               lowTempAbnormality, highTempAbnormality, fallDetected
    );

endinterface

// File: rtl/temp_monitor.sv
// Combinational temperature check.
//   T = base + ((coef * sensor) >> T_SHIFT), 8-bit, max 31 + 28 = 59.
// Ports:
//   i_base  [4:0]  factory temperature offset
//   i_coef  [3:0]  factory temperature gain
//   i_sensor[3:0]  raw sensor reading
//   o_low          T < T_LO
//   o_high         T > T_HI
module temp_monitor
    import healthcare_pkg::*;
(
    input  logic [4:0] i_base,
    input  logic [3:0] i_coef,
    input  logic [3:0] i_sensor,
    output logic       o_low,
    output logic       o_high
);

    logic [7:0] w_prod;
    logic [7:0] w_scaled;
    logic [7:0] w_temp;

    always_comb begin
        w_prod   = {4'b0, i_coef} * {4'b0, i_sensor};
        w_scaled = w_prod >> T_SHIFT;
        w_temp   = {3'b0, i_base} + w_scaled;
        o_low    = (w_temp < T_LO);
        o_high   = (w_temp > T_HI);
    end

endmodule

// File: rtl/healthcare_system_phase1.sv
// Phase-1 patient-monitor core. Each clock evaluates one sensor sample and
// registers the abnormality flags (latency 1, no history between samples).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   pressureData  [5:0]  pressure code        -> presureAbnormality
//   bloodPH [3:0], bloodType [2:0]            -> bloodAbnormality
//   bloodSensor   [7:0]  glucose byte         -> glycemicIndex [3:0]
//   factotyBaseTemp/TempCoef, tempSensorValue -> low/highTempAbnormality
//   fdSensorValue, fdFactoryValue [7:0]       -> fallDetected
module healthcare_system_phase1
    import healthcare_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] pressureData,
    input  logic [3:0] bloodPH,
    input  logic [2:0] bloodType,
    input  logic [7:0] fdSensorValue,
    input  logic [7:0] fdFactoryValue,
    input  logic [7:0] bloodSensor,
    input  logic [4:0] factotyBaseTemp,
    input  logic [3:0] factotyTempCoef,
    input  logic [3:0] tempSensorValue,
    output logic       presureAbnormality,
    output logic       bloodAbnormality,
    output logic [3:0] glycemicIndex,
    output logic       lowTempAbnormality,
    output logic       highTempAbnormality,
    output logic       fallDetected
);

    logic       w_pressure_abn;
    logic       w_blood_abn;
    logic [4:0] w_gly_sum;
    logic [3:0] w_gly_idx;
    logic       w_fall;
    logic       w_temp_low;
    logic       w_temp_high;

    logic       r_pressure_abn;
    logic       r_blood_abn;
    logic [3:0] r_gly_idx;
    logic       r_temp_low;
    logic       r_temp_high;
    logic       r_fall;

    always_comb begin
        w_pressure_abn = (pressureData < P_LO) || (pressureData > P_HI);
        w_blood_abn    = ph_abnormal(bloodPH, bloodType);
        w_gly_sum      = {1'b0, bloodSensor[7:4]} + {1'b0, bloodSensor[3:0]};
        // Sum carry means the nibble sum exceeded 15: saturate.
        w_gly_idx      = w_gly_sum[4] ? 4'hF : w_gly_sum[3:0];
        w_fall         = (fdSensorValue > fdFactoryValue);
    end

    temp_monitor u_temp_monitor (
        .i_base   (factotyBaseTemp),
        .i_coef   (factotyTempCoef),
        .i_sensor (tempSensorValue),
        .o_low    (w_temp_low),
        .o_high   (w_temp_high)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pressure_abn <= 1'b0;
            r_blood_abn    <= 1'b0;
            r_gly_idx      <= '0;
            r_temp_low     <= 1'b0;
            r_temp_high    <= 1'b0;
            r_fall         <= 1'b0;
        end else begin
            r_pressure_abn <= w_pressure_abn;
            r_blood_abn    <= w_blood_abn;
            r_gly_idx      <= w_gly_idx;
            r_temp_low     <= w_temp_low;
            r_temp_high    <= w_temp_high;
            r_fall         <= w_fall;
        end
    end

    assign presureAbnormality  = r_pressure_abn;
    assign bloodAbnormality    = r_blood_abn;
    assign glycemicIndex       = r_gly_idx;
    assign lowTempAbnormality  = r_temp_low;
    assign highTempAbnormality = r_temp_high;
    assign fallDetected        = r_fall;

endmodule

// File: tb/tb_healthcare_system_phase1.sv
// Scoreboard bench for healthcare_system_phase1: each driven sample pushes its
// expected flags; the flags are popped and compared one cycle later.
module tb_healthcare_system_phase1;

    typedef struct packed {
        logic       p;
        logic       b;
        logic [3:0] g;
        logic       lo;
        logic       hi;
        logic       fall;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    exp_t sb_q[$];
    exp_t last_e;

    healthcare_system_phase1_if hif();

    healthcare_system_phase1 dut (
        .clk                 (clk),
        .rst                 (rst),
        .pressureData        (hif.pressureData),
        .bloodPH             (hif.bloodPH),
        .bloodType           (hif.bloodType),
        .fdSensorValue       (hif.fdSensorValue),
        .fdFactoryValue      (hif.fdFactoryValue),
        .bloodSensor         (hif.bloodSensor),
        .factotyBaseTemp     (hif.factotyBaseTemp),
        .factotyTempCoef     (hif.factotyTempCoef),
        .tempSensorValue     (hif.tempSensorValue),
        .presureAbnormality  (hif.presureAbnormality),
        .bloodAbnormality    (hif.bloodAbnormality),
        .glycemicIndex       (hif.glycemicIndex),
        .lowTempAbnormality  (hif.lowTempAbnormality),
        .highTempAbnormality (hif.highTempAbnormality),
        .fallDetected        (hif.fallDetected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check_val({tag, ".pressure"}, 32'(hif.presureAbnormality),  32'(e.p));
        check_val({tag, ".blood"},    32'(hif.bloodAbnormality),    32'(e.b));
        check_val({tag, ".glyc"},     32'(hif.glycemicIndex),       32'(e.g));
        check_val({tag, ".low"},      32'(hif.lowTempAbnormality),  32'(e.lo));
        check_val({tag, ".high"},     32'(hif.highTempAbnormality), 32'(e.hi));
        check_val({tag, ".fall"},     32'(hif.fallDetected),        32'(e.fall));
    endtask

    // Reference written directly from the channel definitions.
    function automatic exp_t model(input logic [5:0] p, input logic [3:0] ph, input logic [2:0] bt,
                                   input logic [7:0] fs, input logic [7:0] ff, input logic [7:0] gs,
                                   input logic [4:0] base, input logic [3:0] coef, input logic [3:0] sens);
        exp_t e;
        int   s;
        int   t;
        e.p = !((int'(p) >= 12) && (int'(p) <= 20));
        if (int'(bt) <= 3) e.b = !((int'(ph) >= 6) && (int'(ph) <= 9));
        else               e.b = !((int'(ph) >= 5) && (int'(ph) <= 8));
        s = int'(gs) / 16 + int'(gs) % 16;
        e.g = (s > 15) ? 4'd15 : 4'(s);
        t = int'(base) + (int'(coef) * int'(sens)) / 8;
        e.lo = (t < 35);
        e.hi = (t > 39);
        e.fall = (int'(fs) > int'(ff));
        return e;
    endfunction

    task automatic drive(input logic [5:0] p, input logic [3:0] ph, input logic [2:0] bt,
                         input logic [7:0] fs, input logic [7:0] ff, input logic [7:0] gs,
                         input logic [4:0] base, input logic [3:0] coef, input logic [3:0] sens,
                         input exp_t e);
        hif.pressureData    = p;
        hif.bloodPH         = ph;
        hif.bloodType       = bt;
        hif.fdSensorValue   = fs;
        hif.fdFactoryValue  = ff;
        hif.bloodSensor     = gs;
        hif.factotyBaseTemp = base;
        hif.factotyTempCoef = coef;
        hif.tempSensorValue = sens;
        sb_q.push_back(e);
    endtask

    task automatic step_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s.sb: got=empty want=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check_outs(tag, e);
            last_e = e;
        end
    endtask

    initial begin
        exp_t zero_e;
        exp_t e;
        logic [5:0] rp;
        logic [3:0] rph;
        logic [2:0] rbt;
        logic [7:0] rfs;
        logic [7:0] rff;
        logic [7:0] rgs;
        logic [4:0] rbase;
        logic [3:0] rcoef;
        logic [3:0] rsens;

        n_total = 0;
        n_bad   = 0;
        zero_e  = '0;
        rst     = 1'b1;
        drive(6'd0, 4'd0, 3'd0, 8'd0, 8'd0, 8'd0, 5'd0, 4'd0, 4'd0, zero_e);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        check_outs("reset", zero_e);
        @(negedge clk);
        rst = 1'b0;

        // Vector A: T = 21 + 180/8 = 43
        drive(6'd8, 4'd0, 3'd0, 8'd8, 8'd32, 8'h00, 5'd21, 4'd15, 4'd12,
              exp_t'{p:1'b1, b:1'b1, g:4'd0, lo:1'b0, hi:1'b1, fall:1'b0});
        step_check("vecA");
        // Vector B: T = 19 + 110/8 = 32, 0xA+0xA saturates
        @(negedge clk);
        drive(6'd16, 4'd6, 3'd1, 8'd32, 8'd32, 8'hAA, 5'd19, 4'd11, 4'd10,
              exp_t'{p:1'b0, b:1'b0, g:4'd15, lo:1'b1, hi:1'b0, fall:1'b0});
        step_check("vecB");
        // Vector C: T = 27 + 210/8 = 53
        @(negedge clk);
        drive(6'd21, 4'd7, 3'd2, 8'd40, 8'd32, 8'h12, 5'd27, 4'd15, 4'd14,
              exp_t'{p:1'b1, b:1'b0, g:4'd3, lo:1'b0, hi:1'b1, fall:1'b1});
        step_check("vecC");

        // Pressure boundaries with neutral other channels (T = 30 + 48/8 = 36)
        @(negedge clk);
        drive(6'd11, 4'd7, 3'd0, 8'd0, 8'd0, 8'h00, 5'd30, 4'd8, 4'd6,
              exp_t'{p:1'b1, b:1'b0, g:4'd0, lo:1'b0, hi:1'b0, fall:1'b0});
        step_check("p11");
        @(negedge clk);
        drive(6'd12, 4'd7, 3'd0, 8'd0, 8'd0, 8'h00, 5'd30, 4'd8, 4'd6,
              exp_t'{p:1'b0, b:1'b0, g:4'd0, lo:1'b0, hi:1'b0, fall:1'b0});
        step_check("p12");
        @(negedge clk);
        drive(6'd20, 4'd7, 3'd0, 8'd0, 8'd0, 8'h00, 5'd30, 4'd8, 4'd6,
              exp_t'{p:1'b0, b:1'b0, g:4'd0, lo:1'b0, hi:1'b0, fall:1'b0});
        step_check("p20");
        @(negedge clk);
        drive(6'd21, 4'd7, 3'd0, 8'd0, 8'd0, 8'h00, 5'd30, 4'd8, 4'd6,
              exp_t'{p:1'b1, b:1'b0, g:4'd0, lo:1'b0, hi:1'b0, fall:1'b0});
        step_check("p21");

        // pH boundaries for type group B
        @(negedge clk);
        drive(6'd16, 4'd9, 3'd4, 8'd0, 8'd0, 8'h00, 5'd30, 4'd8, 4'd6,
              exp_t'{p:1'b0, b:1'b1, g:4'd0, lo:1'b0, hi:1'b0, fall:1'b0});
        step_check("ph9t4");
        @(negedge clk);
        drive(6'd16, 4'd5, 3'd4, 8'd0, 8'd0, 8'h00, 5'd30, 4'd8, 4'd6,
              exp_t'{p:1'b0, b:1'b0, g:4'd0, lo:1'b0, hi:1'b0, fall:1'b0});
        step_check("ph5t4");

        // Latency: inputs change just after an edge; outputs hold until the next edge
        drive(6'd8, 4'd0, 3'd0, 8'd40, 8'd32, 8'hFF, 5'd31, 4'd15, 4'd15,
              exp_t'{p:1'b1, b:1'b1, g:4'd15, lo:1'b0, hi:1'b1, fall:1'b1});
        #2;
        check_outs("hold", last_e);
        step_check("allset");

        // Asynchronous reset mid-cycle, then held across an edge
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", zero_e);
        @(posedge clk);
        #1;
        check_outs("rst_held", zero_e);
        @(negedge clk);
        rst = 1'b0;
        drive(6'd21, 4'd7, 3'd2, 8'd40, 8'd32, 8'h12, 5'd27, 4'd15, 4'd14,
              exp_t'{p:1'b1, b:1'b0, g:4'd3, lo:1'b0, hi:1'b1, fall:1'b1});
        step_check("post_rst");

        // Random samples against the reference
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rp    = 6'($urandom_range(0, 63));
            rph   = 4'($urandom_range(0, 15));
            rbt   = 3'($urandom_range(0, 7));
            rfs   = 8'($urandom_range(0, 255));
            rff   = (i % 4 == 0) ? rfs : 8'($urandom_range(0, 255));
            rgs   = 8'($urandom_range(0, 255));
            rbase = 5'($urandom_range(0, 31));
            rcoef = 4'($urandom_range(0, 15));
            rsens = 4'($urandom_range(0, 15));
            e = model(rp, rph, rbt, rfs, rff, rgs, rbase, rcoef, rsens);
            drive(rp, rph, rbt, rfs, rff, rgs, rbase, rcoef, rsens, e);
            step_check("rand");
        end

        if (sb_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_drain: got=%0d want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
